// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the first low pulse (start bit of a 0x55 sync char) on the rx line
// and reports the {baseClock_freq, divRatio} pair whose bit-time window contains it.
// Optional build macro: UART_AUTOBAUD_CONFIRM_EN adds a MEAS_HI state that also times the
// following high bit and requires both pulses to land in the same window.
module uart_autobaud #(
  parameter int unsigned CLOCK_PERIOD = 10,
  parameter int unsigned TOL_SHIFT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       rx,
  output logic       busy,
  output logic       lock,
  output logic       err,
  output logic       baseClock_freq,
  output logic [2:0] divRatio
);

  // Nominal bit time in clk cycles for candidate idx = {s, d[2:0]}
  function automatic longint unsigned nom_cnt(input int unsigned idx);
    longint unsigned base;
    base = (idx >= 8) ? 64'd460800 : 64'd76800;
    return 64'd1000000000 / ((base >> (idx % 8)) * 64'(CLOCK_PERIOD));
  endfunction

  localparam longint unsigned NMAX   = nom_cnt(7);
  localparam longint unsigned HI_MAX = NMAX + (NMAX >> TOL_SHIFT);
  localparam longint unsigned NMIN   = nom_cnt(8);
  localparam longint unsigned LO_MIN = NMIN - (NMIN >> TOL_SHIFT);
  localparam int unsigned     CW     = $clog2(HI_MAX + 1);
  localparam int unsigned     HI_RUN = 16;

  localparam logic [CW-1:0] HI_MAX_C = CW'(HI_MAX);
  localparam logic [CW-1:0] LO_MIN_C = CW'(LO_MIN);
  localparam logic [CW-1:0] HI_RUN_C = CW'(HI_RUN - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_HI, WAIT_FALL, MEAS_LO, MEAS_HI, CLASSIFY, DONE, ERR
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          lock_q, lock_d;
  logic          err_q, err_d;
  logic          freq_q, freq_d;
  logic [2:0]    div_q, div_d;
  logic          rx_meta_q, rx_s_q;

  logic [CW-1:0] cnt_inc_c;
  logic [CW-1:0] l_c;
  logic [15:0]   hit_l_c;
  logic [15:0]   hit_c;
  logic          win_ok_c;
  logic [3:0]    win_idx_c;

`ifdef UART_AUTOBAUD_CONFIRM_EN
  logic [CW-1:0] l_q, l_d;
  logic [15:0]   hit_h_c;
  assign l_c   = l_q;
  assign hit_c = hit_l_c & hit_h_c;
`else
  assign l_c   = cnt_q;
  assign hit_c = hit_l_c;
`endif

  assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  // Per-candidate tolerance window comparators
  for (genvar g = 0; g < 16; g++) begin : g_win
    localparam longint unsigned NOM = nom_cnt(g);
    localparam logic [CW-1:0]   LO  = CW'(NOM - (NOM >> TOL_SHIFT));
    localparam logic [CW-1:0]   HI  = CW'(NOM + (NOM >> TOL_SHIFT));
    assign hit_l_c[g] = (l_c >= LO) && (l_c <= HI);
`ifdef UART_AUTOBAUD_CONFIRM_EN
    assign hit_h_c[g] = (cnt_q >= LO) && (cnt_q <= HI);
`endif
  end

  // Encode the (at most one) matching window
  always_comb begin
    win_ok_c  = 1'b0;
    win_idx_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hit_c[i]) begin
        win_ok_c  = 1'b1;
        win_idx_c = 4'(i);
      end
    end
  end

  // Two-flop synchronizer for the asynchronous rx line
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      freq_q  <= 1'b0;
      div_q   <= 3'd0;
`ifdef UART_AUTOBAUD_CONFIRM_EN
      l_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      freq_q  <= freq_d;
      div_q   <= div_d;
`ifdef UART_AUTOBAUD_CONFIRM_EN
      l_q     <= l_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    lock_d  = lock_q;
    err_d   = err_q;
    freq_d  = freq_q;
    div_d   = div_q;
`ifdef UART_AUTOBAUD_CONFIRM_EN
    l_d     = l_q;
`endif
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      lock_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_d = WAIT_HI;
            cnt_d   = '0;
            busy_d  = 1'b1;
            lock_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        WAIT_HI: begin
          // Line must have been idle long enough to trust the next fall as a start bit
          if (rx_s_q) begin
            if (cnt_q == HI_RUN_C) begin
              state_d = WAIT_FALL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            cnt_d = '0;
          end
        end
        WAIT_FALL: begin
          if (!rx_s_q) begin
            state_d = MEAS_LO;
            cnt_d   = CW'(1);
          end
        end
        MEAS_LO: begin
          if (!rx_s_q) begin
            if (cnt_q > HI_MAX_C) begin
              state_d = ERR;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
`ifdef UART_AUTOBAUD_CONFIRM_EN
            // Reject glitches before timing the high bit, so the next fall starts fresh
            if (cnt_q < LO_MIN_C) begin
              state_d = WAIT_FALL;
            end else begin
              state_d = MEAS_HI;
              l_d     = cnt_q;
              cnt_d   = CW'(1);
            end
`else
            state_d = CLASSIFY;
`endif
          end
        end
`ifdef UART_AUTOBAUD_CONFIRM_EN
        MEAS_HI: begin
          if (rx_s_q) begin
            if (cnt_q > HI_MAX_C) begin
              state_d = ERR;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end else begin
            state_d = CLASSIFY;
          end
        end
`endif
        CLASSIFY: begin
          if (l_c < LO_MIN_C) begin
            state_d = WAIT_FALL;
          end else if (win_ok_c) begin
            state_d = DONE;
            busy_d  = 1'b0;
            lock_d  = 1'b1;
            freq_d  = win_idx_c[3];
            div_d   = win_idx_c[2:0];
          end else begin
            state_d = ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign lock           = lock_q;
  assign err            = err_q;
  assign baseClock_freq = freq_q;
  assign divRatio       = div_q;

endmodule
